// File: rtl/id_hazard_scoreboard_pkg.sv
// id_hazard_scoreboard_pkg
//   Shared constants for the ID-stage hazard scoreboard: latency-class
//   encodings and the "no forwarding" select value.
package id_hazard_scoreboard_pkg;

    localparam logic [1:0] LAT_CLASS_ALU  = 2'd0;
    localparam logic [1:0] LAT_CLASS_LOAD = 2'd1;
    localparam logic [1:0] LAT_CLASS_LONG = 2'd2;

    // fwd_sel value meaning "take the operand from the register file"
    localparam int FWD_SEL_NONE = 0;

endpackage

// File: rtl/id_hazard_scoreboard_read_port.sv
// sb_read_port
//   Single decode read-port lookup against one scoreboard entry.
//   Ports:
//     busy, age, ready_age : fields of the entry addressed by this port
//                            (busy must already be forced low for x0)
//     en, late             : operand used / operand consumed one stage later
//     fwd_sel              : 0 = register file, k = forward from stage k-1
//     hazard               : operand not yet forwardable, decode must stall
module sb_read_port
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int FWD_W = 2
) (
    input  logic             busy,
    input  logic [FWD_W-1:0] age,
    input  logic [FWD_W-1:0] ready_age,
    input  logic             en,
    input  logic             late,
    output logic [FWD_W-1:0] fwd_sel,
    output logic             hazard
);

    // Two extra bits so ready_age - late cannot wrap below zero.
    logic signed [FWD_W+1:0] age_s;
    logic signed [FWD_W+1:0] need_s;

    always_comb begin
        age_s   = signed'({2'b00, age});
        need_s  = signed'({2'b00, ready_age}) - signed'({{(FWD_W+1){1'b0}}, late});
        fwd_sel = busy ? (age + FWD_W'(1)) : FWD_W'(FWD_SEL_NONE);
        hazard  = busy & en & (age_s < need_s);
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard
//   Per-register scoreboard for the ID stage. Each register x1..x31 tracks
//   its youngest in-flight producer (busy, age, ready_age). Each decode read
//   port gets a forwarding-stage select and a hazard; any hazard stalls.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     adv             : pipeline advances (0 = downstream freeze, state holds)
//     flush_ex        : squash instruction entering EX and age-0 entries
//     issue_*         : ID instruction valid / writes rd / rd / latency class
//     rd_en/rd_late   : per-port operand used / consumed one stage later
//     rd_addr         : per-port source register, port 0 in the LSBs
//     fwd_sel         : per-port select, FWD_W bits each, port 0 in the LSBs
//     stall, issued   : decode stall, issue accepted this cycle
//     stall_cycles    : saturating count of stall&adv cycles
//   Optional feature macro: SCOREBOARD_STATS_EN (stall_cycles counter; when
//   undefined, stall_cycles is tied to zero).
module id_hazard_scoreboard
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int NUM_STAGES     = 3,
    parameter int NUM_RD_PORTS   = 3,
    parameter int LOAD_READY_AGE = 1,
    parameter int LONG_READY_AGE = 2,
    localparam int FWD_W         = $clog2(NUM_STAGES + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            adv,
    input  logic                            flush_ex,
    input  logic                            issue_valid,
    input  logic                            issue_rd_we,
    input  logic [4:0]                      issue_rd,
    input  logic [1:0]                      issue_class,
    input  logic [NUM_RD_PORTS-1:0]         rd_en,
    input  logic [NUM_RD_PORTS-1:0]         rd_late,
    input  logic [5*NUM_RD_PORTS-1:0]       rd_addr,
    output logic [FWD_W*NUM_RD_PORTS-1:0]   fwd_sel,
    output logic                            stall,
    output logic                            issued,
    output logic [31:0]                     stall_cycles
);

    logic [31:0]      busy_q, busy_d;
    logic [FWD_W-1:0] age_q [32];
    logic [FWD_W-1:0] age_d [32];
    logic [FWD_W-1:0] rdy_q [32];
    logic [FWD_W-1:0] rdy_d [32];

    logic [FWD_W-1:0]        port_fwd [NUM_RD_PORTS];
    logic [NUM_RD_PORTS-1:0] port_hz;
    logic [FWD_W-1:0]        issue_rdy;

    // Lookup uses registered state only, so an issuing instruction never
    // sees its own rd.
    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        logic [4:0] addr;
        assign addr = rd_addr[5*p +: 5];

        sb_read_port #(.FWD_W(FWD_W)) u_port (
            .busy      (busy_q[addr] & (addr != 5'd0)),
            .age       (age_q[addr]),
            .ready_age (rdy_q[addr]),
            .en        (rd_en[p]),
            .late      (rd_late[p]),
            .fwd_sel   (port_fwd[p]),
            .hazard    (port_hz[p])
        );
    end

    always_comb begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            fwd_sel[FWD_W*p +: FWD_W] = port_fwd[p];
        end
        stall  = |port_hz;
        issued = issue_valid & adv & ~stall & ~flush_ex;
    end

    // Reserved class encoding 3 falls through to ALU timing.
    always_comb begin
        case (issue_class)
            LAT_CLASS_LOAD: issue_rdy = FWD_W'(LOAD_READY_AGE);
            LAT_CLASS_LONG: issue_rdy = FWD_W'(LONG_READY_AGE);
            default:        issue_rdy = '0;
        endcase
    end

    always_comb begin
        busy_d = busy_q;
        age_d  = age_q;
        rdy_d  = rdy_q;
        if (adv) begin
            for (int r = 1; r < 32; r++) begin
                if (busy_q[r]) begin
                    age_d[r] = age_q[r] + FWD_W'(1);
                    if (int'(age_q[r]) + 1 == NUM_STAGES) busy_d[r] = 1'b0;
                    if (flush_ex && age_q[r] == '0)        busy_d[r] = 1'b0;
                end
            end
            // Applied last: the youngest producer overrides (WAW).
            if (issued && issue_rd_we && issue_rd != 5'd0) begin
                busy_d[issue_rd] = 1'b1;
                age_d[issue_rd]  = '0;
                rdy_d[issue_rd]  = issue_rdy;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            for (int r = 0; r < 32; r++) begin
                age_q[r] <= '0;
                rdy_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            age_q  <= age_d;
            rdy_q  <= rdy_d;
        end
    end

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && adv && stall_cycles_q != 32'hFFFF_FFFF) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cycles_q <= '0;
        else        stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
module tb_id_hazard_scoreboard;
    localparam logic [1:0] ALU = 2'd0;
    localparam logic [1:0] LD  = 2'd1;
    localparam logic [1:0] LG  = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        adv = 1'b1;
    logic        flush_ex = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_rd_we = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [1:0]  issue_class = '0;
    logic [2:0]  rd_en = '0;
    logic [2:0]  rd_late = '0;
    logic [14:0] rd_addr = '0;
    logic [5:0]  fwd_sel;
    logic        stall;
    logic        issued;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    id_hazard_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .adv          (adv),
        .flush_ex     (flush_ex),
        .issue_valid  (issue_valid),
        .issue_rd_we  (issue_rd_we),
        .issue_rd     (issue_rd),
        .issue_class  (issue_class),
        .rd_en        (rd_en),
        .rd_late      (rd_late),
        .rd_addr      (rd_addr),
        .fwd_sel      (fwd_sel),
        .stall        (stall),
        .issued       (issued),
        .stall_cycles (stall_cycles)
    );

    typedef struct {
        string       name;
        logic [5:0]  fwd;
        logic        st;
        logic        isd;
        bit          chk_sc;
        logic [31:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit          nxt_chk_sc = 0;
    logic [31:0] nxt_sc = '0;

`ifdef SCOREBOARD_STATS_EN
    localparam logic [31:0] SC_AFTER_TWO = 32'd2;
`else
    localparam logic [31:0] SC_AFTER_TWO = 32'd0;
`endif

    // Drive one cycle of stimulus and queue what the DUT must show.
    task automatic step(input string nm, input bit rst, input bit iv, input bit we,
                        input logic [4:0] rd, input logic [1:0] cls, input bit advv,
                        input bit fl, input logic [2:0] en, input logic [2:0] late,
                        input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [1:0] f0, input logic [1:0] f1, input logic [1:0] f2,
                        input bit st, input bit isd);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n       = ~rst;
        issue_valid = iv;
        issue_rd_we = we;
        issue_rd    = rd;
        issue_class = cls;
        adv         = advv;
        flush_ex    = fl;
        rd_en       = en;
        rd_late     = late;
        rd_addr     = {a2, a1, a0};
        e.name   = nm;
        e.fwd    = {f2, f1, f0};
        e.st     = st;
        e.isd    = isd;
        e.chk_sc = nxt_chk_sc;
        e.sc     = nxt_sc;
        exp_q.push_back(e);
        nxt_chk_sc = 0;
    endtask

    task automatic idle(input string nm);
        step(nm, 0, 0, 0, 0, ALU, 1, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (fwd_sel !== e.fwd) begin
                n_bad++;
                $display("FAIL %s fwd_sel: got %b want %b", e.name, fwd_sel, e.fwd);
            end
            n_cmp++;
            if (stall !== e.st) begin
                n_bad++;
                $display("FAIL %s stall: got %b want %b", e.name, stall, e.st);
            end
            n_cmp++;
            if (issued !== e.isd) begin
                n_bad++;
                $display("FAIL %s issued: got %b want %b", e.name, issued, e.isd);
            end
            if (e.chk_sc) begin
                n_cmp++;
                if (stall_cycles !== e.sc) begin
                    n_bad++;
                    $display("FAIL %s stall_cycles: got %0d want %0d", e.name, stall_cycles, e.sc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //   name       rst iv we rd  cls adv fl en      late    a0 a1 a2  f0 f1 f2 st isd
        nxt_chk_sc = 1; nxt_sc = 0;
        step("reset",    1, 0, 0, 0,  ALU, 1, 0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 0, 0);
        // ALU producer walks through EX/MEM/WB then retires
        step("t1_iss",   0, 1, 1, 5,  ALU, 1, 0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 0, 1);
        step("t1_age0",  0, 0, 0, 0,  ALU, 1, 0, 3'b001, 3'b000, 5, 0, 0,  1, 0, 0, 0, 0);
        step("t1_age1",  0, 0, 0, 0,  ALU, 1, 0, 3'b001, 3'b000, 5, 0, 0,  2, 0, 0, 0, 0);
        step("t1_age2",  0, 0, 0, 0,  ALU, 1, 0, 3'b001, 3'b000, 5, 0, 0,  3, 0, 0, 0, 0);
        step("t1_ret",   0, 0, 0, 0,  ALU, 1, 0, 3'b001, 3'b000, 5, 0, 0,  0, 0, 0, 0, 0);
        // load-use: one stall, then forward from MEM
        step("t2_iss",   0, 1, 1, 6,  LD,  1, 0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 0, 1);
        step("t2_stall", 0, 1, 0, 0,  ALU, 1, 0, 3'b010, 3'b000, 0, 6, 0,  0, 1, 0, 1, 0);
        step("t2_go",    0, 1, 0, 0,  ALU, 1, 0, 3'b010, 3'b000, 0, 6, 0,  0, 2, 0, 0, 1);
        idle("t2_idle");
        // store data consumed late: no stall
        step("t3_iss",   0, 1, 1, 10, LD,  1, 0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 0, 1);
        step("t3_late",  0, 1, 0, 0,  ALU, 1, 0, 3'b010, 3'b010, 0, 10, 0, 0, 1, 0, 0, 1);
        // long latency with a 3-cycle freeze inside the stall window
        step("t4_iss",   0, 1, 1, 7,  LG,  1, 0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 0, 1);
        step("t4_s0",    0, 1, 0, 0,  ALU, 1, 0, 3'b001, 3'b000, 7, 0, 0,  1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++)
            step("t4_frz", 0, 1, 0, 0,  ALU, 0, 0, 3'b001, 3'b000, 7, 0, 0,  2, 0, 0, 1, 0);
        step("t4_s1",    0, 1, 0, 0,  ALU, 1, 0, 3'b001, 3'b000, 7, 0, 0,  2, 0, 0, 1, 0);
        step("t4_go",    0, 1, 0, 0,  ALU, 1, 0, 3'b001, 3'b000, 7, 0, 0,  3, 0, 0, 0, 1);
        // WAW: younger load overrides ALU producer of x8
        step("t5_alu",   0, 1, 1, 8,  ALU, 1, 0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 0, 1);
        step("t5_ld",    0, 1, 1, 8,  LD,  1, 0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 0, 1);
        step("t5_waw",   0, 1, 0, 0,  ALU, 1, 0, 3'b001, 3'b000, 8, 0, 0,  1, 0, 0, 1, 0);
        idle("t5_idle0");
        idle("t5_idle1");
        // flushed load leaves the older ALU entry of x11 intact
        step("t5_alu2",  0, 1, 1, 11, ALU, 1, 0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 0, 1);
        step("t5_age1",  0, 0, 0, 0,  ALU, 1, 0, 3'b001, 3'b000, 11, 0, 0, 1, 0, 0, 0, 0);
        step("t5_flush", 0, 1, 1, 11, LD,  1, 1, 3'b001, 3'b000, 11, 0, 0, 2, 0, 0, 0, 0);
        step("t5_kept",  0, 0, 0, 0,  ALU, 1, 0, 3'b001, 3'b000, 11, 0, 0, 3, 0, 0, 0, 0);
        // flush squashes an entry sitting at age 0
        step("t5_alu3",  0, 1, 1, 12, ALU, 1, 0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 0, 1);
        step("t5_sq",    0, 0, 0, 0,  ALU, 1, 1, 3'b001, 3'b000, 12, 0, 0, 1, 0, 0, 0, 0);
        step("t5_gone",  0, 0, 0, 0,  ALU, 1, 0, 3'b001, 3'b000, 12, 0, 0, 0, 0, 0, 0, 0);
        // no issue while frozen
        step("frz_iss",  0, 1, 1, 14, ALU, 0, 0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 0, 0);
        step("frz_chk",  0, 0, 0, 0,  ALU, 1, 0, 3'b001, 3'b000, 14, 0, 0, 0, 0, 0, 0, 0);
        // x0 is never tracked
        step("x0_iss",   0, 1, 1, 0,  ALU, 1, 0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 0, 1);
        step("x0_rd",    0, 0, 0, 0,  ALU, 1, 0, 3'b001, 3'b000, 0, 0, 0,  0, 0, 0, 0, 0);
        // async reset with a busy long-latency entry on port 2
        step("t6_iss",   0, 1, 1, 13, LG,  1, 0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 0, 1);
        step("t6_pre",   0, 0, 0, 0,  ALU, 1, 0, 3'b100, 3'b000, 0, 0, 13, 0, 0, 1, 1, 0);
        nxt_chk_sc = 1; nxt_sc = 0;
        step("t6_rst",   1, 0, 0, 0,  ALU, 1, 0, 3'b100, 3'b000, 0, 0, 13, 0, 0, 0, 0, 0);
        // load-use twice: stall counter sees exactly two stall cycles
        step("s_iss1",   0, 1, 1, 6,  LD,  1, 0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 0, 1);
        step("s_st1",    0, 1, 0, 0,  ALU, 1, 0, 3'b010, 3'b000, 0, 6, 0,  0, 1, 0, 1, 0);
        step("s_go1",    0, 1, 0, 0,  ALU, 1, 0, 3'b010, 3'b000, 0, 6, 0,  0, 2, 0, 0, 1);
        step("s_iss2",   0, 1, 1, 6,  LD,  1, 0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 0, 1);
        step("s_st2",    0, 1, 0, 0,  ALU, 1, 0, 3'b010, 3'b000, 0, 6, 0,  0, 1, 0, 1, 0);
        step("s_go2",    0, 1, 0, 0,  ALU, 1, 0, 3'b010, 3'b000, 0, 6, 0,  0, 2, 0, 0, 1);
        nxt_chk_sc = 1; nxt_sc = SC_AFTER_TWO;
        idle("s_cnt");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
